usb_host_sched: RTL and testbench

Host-mode transaction scheduler above `usb_link`. It round-robins among N_EP endpoint requests and issues the IN or OUT token through the token port. It then sequences the data and handshake phases: it triggers the data source or waits for received data, returns ACK, and waits for the device handshake. Timeouts and CRC errors are retried; per-endpoint data toggles are tracked. One completion status is reported per transaction.

---
 rtl/usb_pkg.sv | 33 +++
 rtl/rr_arb.sv | 32 +++
 rtl/usb_host_sched.sv | 239 +++++++++++++++++++++++
 tb/tb_usb_host_sched.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_pkg.sv
// Shared definitions for the USB host scheduler: PID codes, completion status and FSM states.
package usb_pkg;

    localparam logic [3:0] PidOut   = 4'b0001;
    localparam logic [3:0] PidIn    = 4'b1001;
    localparam logic [3:0] PidAck   = 4'b0010;
    localparam logic [3:0] PidNak   = 4'b1010;
    localparam logic [3:0] PidStall = 4'b1110;
    localparam logic [3:0] PidData0 = 4'b0011;
    localparam logic [3:0] PidData1 = 4'b1011;

    typedef enum logic [1:0] {
        StsAck   = 2'd0,
        StsNak   = 2'd1,
        StsStall = 2'd2,
        StsErr   = 2'd3
    } status_e;

    typedef enum logic [2:0] {
        StIdle,
        StToken,
        StOutData,
        StWaitHs,
        StWaitData,
        StSendAck,
        StDone
    } state_e;

    function automatic logic [3:0] data_pid(input logic tog);
        return tog ? PidData1 : PidData0;
    endfunction

endpackage

// File: rtl/rr_arb.sv
// Round-robin arbiter: grants the first requester strictly after ptr_i, wrapping around.
module rr_arb #(
    parameter int unsigned NReq = 4,
    parameter int unsigned IdxW = 2
) (
    input  logic [NReq-1:0] req_i,
    input  logic [IdxW-1:0] ptr_i,
    output logic [NReq-1:0] gnt_o,
    output logic [IdxW-1:0] idx_o,
    output logic            valid_o
);

    always_comb begin
        int unsigned j;
        logic        found;
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        j     = 0;
        // Offset NReq revisits ptr_i itself last, so the previous winner has lowest priority.
        for (int unsigned i = 1; i <= NReq; i++) begin
            j = (32'(ptr_i) + i) % NReq;
            if (!found && req_i[IdxW'(j)]) begin
                found            = 1'b1;
                gnt_o[IdxW'(j)]  = 1'b1;
                idx_o            = IdxW'(j);
            end
        end
        valid_o = found;
    end

endmodule

// File: rtl/usb_host_sched.sv
// Host transaction scheduler: arbitrates endpoint requests, runs token/data/handshake phases,
// retries timeouts and CRC errors, and tracks per-endpoint data toggles.
module usb_host_sched
    import usb_pkg::*;
#(
    parameter int unsigned N_EP      = 4,
    parameter int unsigned RETRY_MAX = 3,
    localparam int unsigned EPW      = (N_EP > 1) ? $clog2(N_EP) : 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            en_i,
    input  logic [6:0]      dev_addr_i,
    input  logic [N_EP-1:0] req_i,
    input  logic [N_EP-1:0] req_dir_i,
    input  logic [N_EP-1:0] tog_clr_i,
    output logic [3:0]      tx_pid_o,
    output logic [6:0]      tx_addr_o,
    output logic [3:0]      tx_endp_o,
    output logic            tx_valid_o,
    input  logic            tx_ready_i,
    output logic            out_go_o,
    output logic [3:0]      out_pid_o,
    input  logic            out_sent_i,
    input  logic            rx_pid_en_i,
    input  logic [3:0]      rx_pid_i,
    input  logic            rx_lt_eop_i,
    input  logic            crc16_err_i,
    input  logic            time_out_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [EPW-1:0]  done_ep_o,
    output logic [1:0]      done_st_o
);

    localparam int unsigned RW = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;

    state_e          state_q, state_d;
    logic [EPW-1:0]  ptr_q, ptr_d;
    logic [EPW-1:0]  ep_q, ep_d;
    logic            dir_q, dir_d;
    logic [RW-1:0]   retry_q, retry_d;
    logic [N_EP-1:0] tog_q, tog_d;
    logic            rx_tog_q, rx_tog_d;
    logic            out_go_q, out_go_d;
    logic [3:0]      out_pid_q, out_pid_d;
    logic [EPW-1:0]  done_ep_q, done_ep_d;
    status_e         done_st_q, done_st_d;

    logic [N_EP-1:0] arb_gnt;
    logic [EPW-1:0]  arb_idx;
    logic            arb_valid;

    logic            tog_flip;
    logic            retry_req;
    logic            fin;
    status_e         fin_st;

    rr_arb #(
        .NReq (N_EP),
        .IdxW (EPW)
    ) u_rr_arb (
        .req_i   (req_i),
        .ptr_i   (ptr_q),
        .gnt_o   (arb_gnt),
        .idx_o   (arb_idx),
        .valid_o (arb_valid)
    );

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        ep_d       = ep_q;
        dir_d      = dir_q;
        retry_d    = retry_q;
        rx_tog_d   = rx_tog_q;
        out_pid_d  = out_pid_q;
        done_ep_d  = done_ep_q;
        done_st_d  = done_st_q;
        tog_flip   = 1'b0;
        retry_req  = 1'b0;
        fin        = 1'b0;
        fin_st     = StsAck;
        tx_valid_o = 1'b0;
        tx_pid_o   = '0;
        tx_addr_o  = '0;
        tx_endp_o  = '0;

        unique case (state_q)
            StIdle: begin
                if (en_i && arb_valid) begin
                    ep_d    = arb_idx;
                    dir_d   = |(req_dir_i & arb_gnt);
                    retry_d = '0;
                    state_d = StToken;
                end
            end
            StToken: begin
                tx_valid_o = 1'b1;
                tx_pid_o   = dir_q ? PidIn : PidOut;
                tx_addr_o  = dev_addr_i;
                tx_endp_o  = 4'(ep_q);
                if (tx_ready_i) begin
                    state_d = dir_q ? StWaitData : StOutData;
                    if (!dir_q) begin
                        out_pid_d = data_pid(tog_q[ep_q]);
                    end
                end
            end
            StOutData: begin
                if (out_sent_i) begin
                    state_d = StWaitHs;
                end
            end
            StWaitHs: begin
                if (rx_pid_en_i) begin
                    case (rx_pid_i)
                        PidAck: begin
                            tog_flip = 1'b1;
                            fin      = 1'b1;
                            fin_st   = StsAck;
                        end
                        PidNak: begin
                            fin    = 1'b1;
                            fin_st = StsNak;
                        end
                        PidStall: begin
                            fin    = 1'b1;
                            fin_st = StsStall;
                        end
                        default: retry_req = 1'b1;
                    endcase
                end else if (time_out_i) begin
                    retry_req = 1'b1;
                end
            end
            StWaitData: begin
                if (rx_pid_en_i && (rx_pid_i == PidNak || rx_pid_i == PidStall)) begin
                    fin    = 1'b1;
                    fin_st = (rx_pid_i == PidNak) ? StsNak : StsStall;
                end else begin
                    if (rx_pid_en_i && (rx_pid_i == PidData0 || rx_pid_i == PidData1)) begin
                        rx_tog_d = rx_pid_i[3];
                    end
                    if (rx_lt_eop_i) begin
                        if (crc16_err_i) begin
                            retry_req = 1'b1;
                        end else begin
                            state_d = StSendAck;
                        end
                    end else if (time_out_i && !rx_pid_en_i) begin
                        retry_req = 1'b1;
                    end
                end
            end
            StSendAck: begin
                tx_valid_o = 1'b1;
                tx_pid_o   = PidAck;
                if (tx_ready_i) begin
                    // A toggle mismatch is a retransmitted packet: still ACK it, but keep the toggle.
                    tog_flip = (rx_tog_q == tog_q[ep_q]);
                    fin      = 1'b1;
                    fin_st   = StsAck;
                end
            end
            StDone: begin
                ptr_d   = ep_q;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (retry_req) begin
            if (retry_q < RW'(RETRY_MAX)) begin
                retry_d = retry_q + RW'(1);
                state_d = StToken;
            end else begin
                fin    = 1'b1;
                fin_st = StsErr;
            end
        end

        if (fin) begin
            state_d   = StDone;
            done_ep_d = ep_q;
            done_st_d = fin_st;
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < N_EP; i++) begin
            if (tog_clr_i[i]) begin
                tog_d[i] = 1'b0;
            end else if (tog_flip && ep_q == EPW'(i)) begin
                tog_d[i] = ~tog_q[i];
            end else begin
                tog_d[i] = tog_q[i];
            end
        end
    end

    assign out_go_d = (state_d == StOutData) && (state_q != StOutData);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            ptr_q     <= EPW'(N_EP - 1);
            ep_q      <= '0;
            dir_q     <= 1'b0;
            retry_q   <= '0;
            tog_q     <= '0;
            rx_tog_q  <= 1'b0;
            out_go_q  <= 1'b0;
            out_pid_q <= PidData0;
            done_ep_q <= '0;
            done_st_q <= StsAck;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            ep_q      <= ep_d;
            dir_q     <= dir_d;
            retry_q   <= retry_d;
            tog_q     <= tog_d;
            rx_tog_q  <= rx_tog_d;
            out_go_q  <= out_go_d;
            out_pid_q <= out_pid_d;
            done_ep_q <= done_ep_d;
            done_st_q <= done_st_d;
        end
    end

    assign busy_o    = (state_q != StIdle);
    assign done_o    = (state_q == StDone);
    assign done_ep_o = done_ep_q;
    assign done_st_o = done_st_q;
    assign out_go_o  = out_go_q;
    assign out_pid_o = out_pid_q;

endmodule

// File: tb/tb_usb_host_sched.sv
// Directed and randomized transactions against a behavioural device/toggle model.
module tb_usb_host_sched;

    localparam int NEp      = 4;
    localparam int RetryMax = 3;

    localparam logic [3:0] POut   = 4'b0001;
    localparam logic [3:0] PIn    = 4'b1001;
    localparam logic [3:0] PAck   = 4'b0010;
    localparam logic [3:0] PNak   = 4'b1010;
    localparam logic [3:0] PStall = 4'b1110;

    logic           clk = 1'b0;
    logic           rst, en;
    logic [6:0]     dev_addr;
    logic [NEp-1:0] req, req_dir, tog_clr;
    logic [3:0]     tx_pid, tx_endp, out_pid, rx_pid;
    logic [6:0]     tx_addr;
    logic           tx_valid, tx_ready, out_go, out_sent;
    logic           rx_pid_en, rx_lt_eop, crc16_err, time_out;
    logic           busy, done;
    logic [1:0]     done_ep, done_st;

    int             n_chk  = 0;
    int             n_fail = 0;
    logic [NEp-1:0] tog_m;
    int             ptr_m;

    always #5 clk = ~clk;

    usb_host_sched #(
        .N_EP      (NEp),
        .RETRY_MAX (RetryMax)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .en_i        (en),
        .dev_addr_i  (dev_addr),
        .req_i       (req),
        .req_dir_i   (req_dir),
        .tog_clr_i   (tog_clr),
        .tx_pid_o    (tx_pid),
        .tx_addr_o   (tx_addr),
        .tx_endp_o   (tx_endp),
        .tx_valid_o  (tx_valid),
        .tx_ready_i  (tx_ready),
        .out_go_o    (out_go),
        .out_pid_o   (out_pid),
        .out_sent_i  (out_sent),
        .rx_pid_en_i (rx_pid_en),
        .rx_pid_i    (rx_pid),
        .rx_lt_eop_i (rx_lt_eop),
        .crc16_err_i (crc16_err),
        .time_out_i  (time_out),
        .busy_o      (busy),
        .done_o      (done),
        .done_ep_o   (done_ep),
        .done_st_o   (done_st)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic bit_of(input logic [NEp-1:0] v, input int k);
        logic [NEp-1:0] s;
        s = v >> k;
        return s[0];
    endfunction

    function automatic logic [NEp-1:0] onehot(input int k);
        return NEp'(1) << k;
    endfunction

    // Round-robin rule: first requester after the last served endpoint, wrapping.
    function automatic int next_ep(input logic [NEp-1:0] r, input int p);
        for (int i = 1; i <= NEp; i++) begin
            if (bit_of(r, (p + i) % NEp)) return (p + i) % NEp;
        end
        return -1;
    endfunction

    function automatic logic [3:0] exp_data_pid(input logic t);
        return {t, 3'b011};
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst   = 1'b0;
        tog_m = '0;
        ptr_m = NEp - 1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_txv"}, 32'(tx_valid), 0);
        chk({tag, "_txfields"}, {17'd0, tx_pid, tx_addr, tx_endp}, 0);
        chk({tag, "_outgo"}, 32'(out_go), 0);
        chk({tag, "_outpid"}, 32'(out_pid), 32'h3);
        chk({tag, "_donefields"}, {28'd0, done_ep, done_st}, 0);
    endtask

    task automatic wait_tx(input string tag);
        int n = 0;
        while (!tx_valid && n < 20) begin
            step();
            n++;
        end
        chk({tag, "_valid"}, 32'(tx_valid), 1);
    endtask

    // Holds tx_valid a random number of cycles (with stray PID strobes) before accepting.
    task automatic handshake(input logic [NEp-1:0] clr_v);
        int d = int'($urandom_range(0, 2));
        for (int i = 0; i < d; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                rx_pid_en = 1'b1;
                rx_pid    = PAck;
            end
            step();
            rx_pid_en = 1'b0;
        end
        chk("tx_hold", 32'(tx_valid), 1);
        tx_ready = 1'b1;
        tog_clr  = clr_v;
        step();
        tx_ready = 1'b0;
        tog_clr  = '0;
    endtask

    // fails: attempts that fail before the final response; fin: 0 ACK/good data, 1 NAK, 2 STALL;
    // dtog: received data toggle for IN (-1 = matches expected); clr: tog_clr with final event.
    task automatic txn(input string tag, input int fails, input int fin, input int dtog,
                       input bit clr);
        int   ep, att, exp_st, n;
        logic is_in, rt, rtog;
        ep     = next_ep(req, ptr_m);
        is_in  = bit_of(req_dir, ep);
        att    = 0;
        exp_st = -1;
        while (exp_st < 0) begin
            wait_tx({tag, "_tok"});
            chk({tag, "_tokpid"}, 32'(tx_pid), 32'(is_in ? PIn : POut));
            chk({tag, "_addr"}, 32'(tx_addr), 32'(dev_addr));
            chk({tag, "_endp"}, 32'(tx_endp), ep);
            handshake('0);
            rt = (att < fails);
            if (!is_in) begin
                chk({tag, "_outgo"}, 32'(out_go), 1);
                chk({tag, "_outpid"}, 32'(out_pid), 32'(exp_data_pid(bit_of(tog_m, ep))));
                step();
                chk({tag, "_outgo_pulse"}, 32'(out_go), 0);
                repeat ($urandom_range(0, 2)) step();
                out_sent = 1'b1;
                step();
                out_sent = 1'b0;
                repeat ($urandom_range(0, 2)) step();
                if (rt) begin
                    if ($urandom_range(0, 1) == 1) time_out = 1'b1;
                    else begin
                        rx_pid_en = 1'b1;
                        rx_pid    = 4'b0011;
                    end
                end else begin
                    rx_pid_en = 1'b1;
                    rx_pid    = (fin == 0) ? PAck : (fin == 1) ? PNak : PStall;
                    if (clr) tog_clr = onehot(ep);
                    if (fin == 0) tog_m = tog_m ^ onehot(ep);
                    if (clr) tog_m = tog_m & ~onehot(ep);
                end
                step();
                rx_pid_en = 1'b0;
                time_out  = 1'b0;
                tog_clr   = '0;
            end else begin
                repeat ($urandom_range(0, 2)) step();
                if (rt) begin
                    if ($urandom_range(0, 1) == 1) begin
                        time_out = 1'b1;
                        step();
                        time_out = 1'b0;
                    end else begin
                        rx_pid_en = 1'b1;
                        rx_pid    = 4'b0011;
                        step();
                        rx_pid_en = 1'b0;
                        rx_lt_eop = 1'b1;
                        crc16_err = 1'b1;
                        step();
                        rx_lt_eop = 1'b0;
                        crc16_err = 1'b0;
                    end
                end else if (fin != 0) begin
                    rx_pid_en = 1'b1;
                    rx_pid    = (fin == 1) ? PNak : PStall;
                    step();
                    rx_pid_en = 1'b0;
                end else begin
                    rtog      = (dtog < 0) ? bit_of(tog_m, ep) : dtog[0];
                    rx_pid_en = 1'b1;
                    rx_pid    = exp_data_pid(rtog);
                    step();
                    rx_pid_en = 1'b0;
                    repeat ($urandom_range(0, 2)) step();
                    rx_lt_eop = 1'b1;
                    step();
                    rx_lt_eop = 1'b0;
                    wait_tx({tag, "_ack"});
                    chk({tag, "_ackpid"}, 32'(tx_pid), 32'(PAck));
                    handshake(clr ? onehot(ep) : '0);
                    if (rtog == bit_of(tog_m, ep)) tog_m = tog_m ^ onehot(ep);
                    if (clr) tog_m = tog_m & ~onehot(ep);
                end
            end
            if (rt) begin
                att++;
                if (att > RetryMax) exp_st = 3;
            end else begin
                exp_st = fin;
            end
        end
        n = 0;
        while (!done && n < 10) begin
            step();
            n++;
        end
        chk({tag, "_done"}, 32'(done), 1);
        chk({tag, "_done_ep"}, 32'(done_ep), ep);
        chk({tag, "_done_st"}, 32'(done_st), exp_st);
        ptr_m = ep;
        step();
        chk({tag, "_done_pulse"}, 32'(done), 0);
        chk({tag, "_st_hold"}, 32'(done_st), exp_st);
    endtask

    initial begin
        int order[4] = '{0, 1, 3, 0};
        rst = 1'b0; en = 1'b1; dev_addr = 7'h2A; req = '0; req_dir = '0; tog_clr = '0;
        tx_ready = 1'b0; out_sent = 1'b0; rx_pid_en = 1'b0; rx_pid = '0;
        rx_lt_eop = 1'b0; crc16_err = 1'b0; time_out = 1'b0;
        do_reset();
        chk_reset_outputs("reset");

        // Disabled scheduler never grants.
        en  = 1'b0;
        req = 4'b0100;
        repeat (3) begin
            step();
            chk("en_off_txv", 32'(tx_valid), 0);
        end
        chk("en_off_busy", 32'(busy), 0);
        en = 1'b1;

        // IN ep1 with DATA0, then OUT ep1 exposes the flipped toggle.
        req = 4'b0010; req_dir = 4'b0010;
        txn("in_ep1", 0, 0, 0, 1'b0);
        req_dir = 4'b0000;
        txn("out_ep1", 0, 0, -1, 1'b0);
        chk("ep1_tog_model", 32'(tog_m[1]), 0);
        req = '0;

        // OUT ep0 twice: DATA0 then DATA1.
        req = 4'b0001; req_dir = '0;
        txn("out_ep0_a", 0, 0, -1, 1'b0);
        txn("out_ep0_b", 0, 0, -1, 1'b0);
        req = '0;

        // Grant order after reset with req=1011.
        do_reset();
        req = 4'b1011; req_dir = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            txn("order", 0, 0, -1, 1'b0);
            chk("order_ep", 32'(done_ep), order[i]);
        end
        req = '0;

        // IN ep2 failing every attempt -> ERR, toggle unchanged.
        req = 4'b0100; req_dir = 4'b0100;
        txn("in_err", 4, 0, -1, 1'b0);
        // Make toggle DATA1, send duplicate DATA0, then clear coincident with a flip.
        req_dir = 4'b0000;
        txn("out_ep2", 0, 0, -1, 1'b0);
        req_dir = 4'b0100;
        txn("in_dup", 0, 0, 0, 1'b0);
        req_dir = 4'b0000;
        txn("out_clr", 0, 0, -1, 1'b1);
        txn("out_after_clr", 0, 0, -1, 1'b0);
        req = '0;

        // Reset in the middle of the handshake wait.
        req = 4'b0001; req_dir = '0;
        wait_tx("rst_tok");
        handshake('0);
        step();
        out_sent = 1'b1;
        step();
        out_sent = 1'b0;
        req = '0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        tog_m = '0;
        ptr_m = NEp - 1;
        chk_reset_outputs("mid_rst");
        repeat (3) begin
            step();
            chk("mid_rst_nodone", 32'(done), 0);
        end

        // Randomized transactions.
        for (int i = 0; i < 24; i++) begin
            req      = NEp'($urandom_range(1, 15));
            req_dir  = NEp'($urandom_range(0, 15));
            dev_addr = 7'($urandom_range(0, 127));
            txn("rand", int'($urandom_range(0, 4)), int'($urandom_range(0, 2)),
                int'($urandom_range(0, 2)) - 1, ($urandom_range(0, 3) == 0));
        end
        req = '0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
